// File: rtl/std_dev_stream.sv
// ============================================================================
// Module   : std_dev_stream
// Brief    : Streaming mean / floor population standard deviation of an
//            N_INPUT-sample vector (accumulate + bit-serial square root).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module std_dev_stream #(
  parameter int N_INPUT = 8,
  parameter int SIZE    = 32,
  parameter int SIGNED  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_INPUT*SIZE-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [SIZE-1:0]         mean,
  output logic [SIZE-1:0]         std_dev,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int c_LOG2N = $clog2(N_INPUT);
  localparam int c_SUMW  = SIZE + c_LOG2N;
  localparam int c_SQW   = 2*SIZE + c_LOG2N;
  localparam int c_VW    = 2*SIZE + 2*c_LOG2N;
  localparam int c_CW    = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    VAR   = 3'd2,
    SQRT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                    r_state;
  logic [N_INPUT*SIZE-1:0]   r_data;
  logic [c_LOG2N-1:0]        r_idx;
  logic [c_SUMW-1:0]         r_sum;
  logic [c_SQW-1:0]          r_sumsq;
  logic [SIZE-1:0]           r_mean_nxt;
  logic [2*SIZE-1:0]         r_rad;
  logic [SIZE+1:0]           r_rem;
  logic [SIZE-1:0]           r_root;
  logic [c_CW-1:0]           r_bit;

  logic [SIZE-1:0]           w_x;
  logic                      w_sx;
  logic [c_SUMW-1:0]         w_x_sum;
  logic [2*SIZE-1:0]         w_x_wide;
  logic [2*SIZE-1:0]         w_sq;
  logic                      w_ss;
  logic [c_VW-1:0]           w_sum_wide;
  logic [c_VW-1:0]           w_nsumsq;
  logic [c_VW-1:0]           w_diff;
  logic [2*SIZE-1:0]         w_var;
  logic [SIZE+1:0]           w_rem_sh;
  logic [SIZE+1:0]           w_trial;
  logic                      w_ge;
  logic [SIZE+1:0]           w_rem_nxt;
  logic [SIZE-1:0]           w_root_nxt;

  // Squares are formed modulo the container width; the true values always fit,
  // so sign-extending and multiplying unsigned yields the exact result.
  assign w_x        = r_data[SIZE-1:0];
  assign w_sx       = (SIGNED != 0) && w_x[SIZE-1];
  assign w_x_sum    = {{c_LOG2N{w_sx}}, w_x};
  assign w_x_wide   = {{SIZE{w_sx}}, w_x};
  assign w_sq       = w_x_wide * w_x_wide;

  assign w_ss       = (SIGNED != 0) && r_sum[c_SUMW-1];
  assign w_sum_wide = {{(c_VW-c_SUMW){w_ss}}, r_sum};
  assign w_nsumsq   = {r_sumsq, {c_LOG2N{1'b0}}};
  assign w_diff     = w_nsumsq - w_sum_wide * w_sum_wide;
  assign w_var      = w_diff[c_VW-1:2*c_LOG2N];

  // One restoring square-root step: bring down two radicand bits, try 4q+1.
  assign w_rem_sh   = {r_rem[SIZE-1:0], r_rad[2*SIZE-1:2*SIZE-2]};
  assign w_trial    = {r_root, 2'b01};
  assign w_ge       = (w_rem_sh >= w_trial);
  assign w_rem_nxt  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign w_root_nxt = {r_root[SIZE-2:0], w_ge};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_idx      <= '0;
      r_sum      <= '0;
      r_sumsq    <= '0;
      r_mean_nxt <= '0;
      r_rad      <= '0;
      r_rem      <= '0;
      r_root     <= '0;
      r_bit      <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      mean       <= '0;
      std_dev    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_data   <= in_data;
            r_sum    <= '0;
            r_sumsq  <= '0;
            r_idx    <= '0;
            in_ready <= 1'b0;
            r_state  <= ACCUM;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ACCUM: begin
          r_sum   <= r_sum + w_x_sum;
          r_sumsq <= r_sumsq + {{c_LOG2N{1'b0}}, w_sq};
          r_data  <= r_data >> SIZE;
          r_idx   <= r_idx + 1'b1;
          if (&r_idx) r_state <= VAR;
        end
        VAR: begin
          r_rad      <= w_var;
          r_rem      <= '0;
          r_root     <= '0;
          r_bit      <= c_CW'(SIZE-1);
          r_mean_nxt <= r_sum[c_SUMW-1:c_LOG2N];
          r_state    <= SQRT;
        end
        SQRT: begin
          r_rem  <= w_rem_nxt;
          r_root <= w_root_nxt;
          r_rad  <= r_rad << 2;
          r_bit  <= r_bit - 1'b1;
          if (r_bit == '0) begin
            std_dev   <= w_root_nxt;
            mean      <= r_mean_nxt;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
